demux_frame_driver: RTL and testbench



---
 rtl/demux_frame_driver.sv | 137 +++++++++++++
 tb/tb_demux_frame_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_frame_driver.sv
// Framed serializer feeding a 1-to-4 single-bit demux: start bit, payload LSB-first, gap.
// Define DEMUX_FRAME_DRIVER_PARITY_EN to append an even-parity bit after the payload.
module demux_frame_driver #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_chan,
  output logic              in_ready,
  output logic              din,
  output logic [1:0]        sel,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W);
  localparam logic [3:0]       LAST_GAP = 4'(GAP_CYCLES);

`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, GAP} state_t;
`endif

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        gcnt, gcnt_nxt;
  logic              din_nxt, done_nxt, load, shift_en, end_payload;
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
  logic              par;
`endif

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are computed for the next state so din/busy line up with the state they belong to.
  always_comb begin
    state_nxt   = state;
    din_nxt     = 1'b0;
    done_nxt    = 1'b0;
    load        = 1'b0;
    shift_en    = 1'b0;
    end_payload = 1'b0;
    cnt_nxt     = cnt;
    gcnt_nxt    = gcnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = START;
          din_nxt   = 1'b1;
        end
      end
      START: begin
        state_nxt = DATA;
        din_nxt   = shift[0];
        shift_en  = 1'b1;
        cnt_nxt   = CNT_W'(1);
      end
      DATA: begin
        if (cnt == LAST_BIT) begin
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
          state_nxt = PARITY;
          din_nxt   = par;
`else
          end_payload = 1'b1;
`endif
        end else begin
          din_nxt  = shift[0];
          shift_en = 1'b1;
          cnt_nxt  = cnt + 1'b1;
        end
      end
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
      PARITY: end_payload = 1'b1;
`endif
      GAP: begin
        if (gcnt == LAST_GAP) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          gcnt_nxt = gcnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (end_payload) begin
      if (GAP_CYCLES == 0) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = GAP;
        gcnt_nxt  = 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      din        <= 1'b0;
      sel        <= 2'b00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      cnt        <= cnt_nxt;
      gcnt       <= gcnt_nxt;
      din        <= din_nxt;
      busy       <= (state_nxt != IDLE);
      frame_done <= done_nxt;
      if (load) begin
        shift <= in_data;
        sel   <= in_chan;
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
        par   <= ^in_data;
`endif
      end else if (shift_en) begin
        shift <= shift >> 1;
      end
    end
  end

endmodule

// File: tb/tb_demux_frame_driver.sv
// Directed bench for demux_frame_driver: default instance (DATA_W=8, GAP=2) and a DATA_W=1, GAP=0 instance.
`timescale 1ns/1ps
module tb_demux_frame_driver;

`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = 1 + 8 + P + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] in_chan;
  logic       in_ready, din, busy, frame_done;
  logic [1:0] sel;

  logic       v1, d1, r1, o1, b1, f1;
  logic [1:0] c1, s1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_frame_driver #(.DATA_W(8), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_chan(in_chan),
    .in_ready(in_ready), .din(din), .sel(sel), .busy(busy), .frame_done(frame_done)
  );

  demux_frame_driver #(.DATA_W(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_chan(c1),
    .in_ready(r1), .din(o1), .sel(s1), .busy(b1), .frame_done(f1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected frame bit i: start, payload LSB-first, optional even parity, then gap zeros.
  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b1;
    if (i <= 8) return d[i-1];
    if (P == 1 && i == 9) return ^d;
    return 1'b0;
  endfunction

  task automatic test_reset();
    logic [5:0] got;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_chan = '0;
    v1 = 1'b0; d1 = 1'b0; c1 = '0;
    #12;
    got = {din, sel, busy, in_ready, frame_done};
    checks++;
    if (got !== 6'b0_00_0_1_0) begin
      errors++; $display("FAIL reset_hold: din/sel/busy/rdy/done=%b required %b", got, 6'b000010);
    end
    checks++;
    if ({o1, s1, b1, r1, f1} !== 6'b0_00_0_1_0) begin
      errors++; $display("FAIL reset_hold_w1: got %b required %b", {o1, s1, b1, r1, f1}, 6'b000010);
    end
    @(negedge clk); rst_n = 1'b1;
    step(); step();
    got = {din, sel, busy, in_ready, frame_done};
    checks++;
    if (got !== 6'b0_00_0_1_0) begin
      errors++; $display("FAIL idle_after_reset: got %b required %b", got, 6'b000010);
    end
    // Start a frame on channel 3, then pull reset in the middle of the payload.
    in_valid = 1'b1; in_data = 8'hFF; in_chan = 2'd3;
    step(); in_valid = 1'b0;
    step(); step(); step();
    checks++;
    if ({din, sel, busy, in_ready} !== 5'b1_11_1_0) begin
      errors++; $display("FAIL midframe_state: got %b required %b", {din, sel, busy, in_ready}, 5'b11110);
    end
    #1 rst_n = 1'b0;
    #1;
    got = {din, sel, busy, in_ready, frame_done};
    checks++;
    if (got !== 6'b0_00_0_1_0) begin
      errors++; $display("FAIL async_reset: got %b required %b", got, 6'b000010);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if ({busy, frame_done, in_ready, din} !== 4'b0010) begin
        errors++; $display("FAIL post_reset_idle c%0d: busy/done/rdy/din=%b required 0010", i, {busy, frame_done, in_ready, din});
      end
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input logic [1:0] c);
    logic [5:0] got, req;
    in_valid = 1'b1; in_data = d; in_chan = c;
    step(); in_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      got = {din, sel, busy, in_ready, frame_done};
      req = {exp_bit(d, i), c, 1'b1, 1'b0, 1'b0};
      checks++;
      if (got !== req) begin
        errors++; $display("FAIL %s c%0d: din/sel/busy/rdy/done=%b required %b", name, i, got, req);
      end
      step();
    end
    got = {din, sel, busy, in_ready, frame_done};
    req = {1'b0, c, 1'b0, 1'b1, 1'b1};
    checks++;
    if (got !== req) begin
      errors++; $display("FAIL %s done: got %b required %b", name, got, req);
    end
    step();
    checks++;
    if ({frame_done, busy} !== 2'b00) begin
      errors++; $display("FAIL %s done_pulse: done/busy=%b required 00", name, {frame_done, busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, req;
    in_valid = 1'b1; in_data = 8'h01; in_chan = 2'd0;
    step();
    in_data = 8'h80; in_chan = 2'd3;
    for (int i = 0; i < FL; i++) begin
      got = {din, sel, busy, in_ready, frame_done};
      req = {exp_bit(8'h01, i), 2'd0, 1'b1, 1'b0, 1'b0};
      checks++;
      if (got !== req) begin
        errors++; $display("FAIL b2b_first c%0d: got %b required %b", i, got, req);
      end
      step();
    end
    got = {din, sel, busy, in_ready, frame_done};
    checks++;
    if (got !== 6'b0_00_0_1_1) begin
      errors++; $display("FAIL b2b_gap_idle: got %b required %b", got, 6'b000011);
    end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      got = {din, sel, busy, in_ready, frame_done};
      req = {exp_bit(8'h80, i), 2'd3, 1'b1, 1'b0, 1'b0};
      checks++;
      if (got !== req) begin
        errors++; $display("FAIL b2b_second c%0d: got %b required %b", i, got, req);
      end
      step();
    end
    got = {din, sel, busy, in_ready, frame_done};
    checks++;
    if (got !== 6'b0_11_0_1_1) begin
      errors++; $display("FAIL b2b_second_done: got %b required %b", got, 6'b011011);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy, frame_done, sel} !== 4'b0011) begin
        errors++; $display("FAIL b2b_no_dup c%0d: busy/done/sel=%b required 0011", i, {busy, frame_done, sel});
      end
    end
  endtask

  task automatic test_disturbance();
    logic [5:0] got, req;
    in_valid = 1'b1; in_data = 8'h3C; in_chan = 2'd1;
    step(); in_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      got = {din, sel, busy, in_ready, frame_done};
      req = {exp_bit(8'h3C, i), 2'd1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (got !== req) begin
        errors++; $display("FAIL disturb c%0d: got %b required %b", i, got, req);
      end
      in_data = ~in_data ^ 8'(i);
      in_chan = in_chan + 2'd1;
      step();
    end
    got = {din, sel, busy, in_ready, frame_done};
    checks++;
    if (got !== 6'b0_01_0_1_1) begin
      errors++; $display("FAIL disturb_done: got %b required %b", got, 6'b001011);
    end
    step();
  endtask

  task automatic test_short_nogap();
    logic [5:0] got;
    v1 = 1'b1; d1 = 1'b1; c1 = 2'd1;
    step(); v1 = 1'b0;
    got = {o1, s1, b1, r1, f1};
    checks++;
    if (got !== 6'b1_01_1_0_0) begin
      errors++; $display("FAIL w1_start: got %b required %b", got, 6'b101100);
    end
    step();
    got = {o1, s1, b1, r1, f1};
    checks++;
    if (got !== 6'b1_01_1_0_0) begin
      errors++; $display("FAIL w1_data: got %b required %b", got, 6'b101100);
    end
    step();
    got = {o1, s1, b1, r1, f1};
    checks++;
    if (got !== 6'b0_01_0_1_1) begin
      errors++; $display("FAIL w1_done: got %b required %b", got, 6'b001011);
    end
    v1 = 1'b1; d1 = 1'b0; c1 = 2'd2;
    step(); v1 = 1'b0;
    got = {o1, s1, b1, r1, f1};
    checks++;
    if (got !== 6'b1_10_1_0_0) begin
      errors++; $display("FAIL w1_start2: got %b required %b", got, 6'b110100);
    end
    step();
    got = {o1, s1, b1, r1, f1};
    checks++;
    if (got !== 6'b0_10_1_0_0) begin
      errors++; $display("FAIL w1_data2: got %b required %b", got, 6'b010100);
    end
    step();
    got = {o1, s1, b1, r1, f1};
    checks++;
    if (got !== 6'b0_10_0_1_1) begin
      errors++; $display("FAIL w1_done2: got %b required %b", got, 6'b010011);
    end
    step();
    checks++;
    if ({f1, b1} !== 2'b00) begin
      errors++; $display("FAIL w1_pulse: done/busy=%b required 00", {f1, b1});
    end
  endtask

  initial begin
    test_reset();
    test_frame("frame_a5", 8'hA5, 2'd2);
    test_frame("frame_07", 8'h07, 2'd1);
    test_frame("frame_ff", 8'hFF, 2'd3);
    test_frame("frame_00", 8'h00, 2'd0);
    test_back_to_back();
    test_disturbance();
    test_short_nogap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
